// File: rtl/sq_int_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sq_int_pkg                                            |
// | Purpose  : Shared state encoding and iteration-count helper for  |
// |            the sq_int radix-4 squarer.                           |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package sq_int_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ADD  = 2'd2
   } sq_state_e;

   // Two multiplier bits are retired per cycle, so an even width needs width/2 steps.
   function automatic int iter_cnt(input int width);
      return width >> 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sq_int_r4_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sq_int_r4_step                                        |
// | Purpose  : One radix-4 shift-add step: (acc<<2) + d*mcand.       |
// |            Purely combinational.                                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sq_int_r4_step
   import sq_int_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [1:0]         d,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH+1:0] w_mc_x1;
   logic [WIDTH+1:0] w_mc_x2;
   logic [WIDTH+1:0] w_mc_x3;
   logic [WIDTH+1:0] w_pp;

   assign w_mc_x1 = {2'b00, mcand};
   assign w_mc_x2 = {1'b0, mcand, 1'b0};
   // 3*mcand from a single adder instead of a true multiplier
   assign w_mc_x3 = w_mc_x1 + w_mc_x2;

   // Select the partial product for the current multiplier digit
   always_comb begin
      w_pp = '0;
      case (d)
         2'd0:    w_pp = '0;
         2'd1:    w_pp = w_mc_x1;
         2'd2:    w_pp = w_mc_x2;
         default: w_pp = w_mc_x3;
      endcase
   end

   // The top two accumulator bits are always zero here, since acc is a prefix of root*root
   assign acc_next = {acc[2*WIDTH-3:0], 2'b00} + {{(WIDTH-2){1'b0}}, w_pp};

endmodule
`default_nettype wire

// File: rtl/sq_int.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sq_int                                                |
// | Purpose  : Iterative integer squarer, rad = root*root + rem,     |
// |            radix-4 shift-add, start/busy/valid handshake.        |
// | Config   : SQ_INT_REM_CHECK_EN - enables rem > 2*root flag       |
// |            (rem_err); otherwise rem_err is tied low.             |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module sq_int
   import sq_int_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             valid,
   input  logic [WIDTH-1:0] root,
   input  logic [WIDTH-1:0] rem,
   output logic [WIDTH-1:0] rad,
   output logic             ovf,
   output logic             rem_err
);

   localparam int c_ITER  = iter_cnt(WIDTH);
   localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_ITER - 1);

   sq_state_e r_state;
   sq_state_e w_next;

   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplr;
   logic [WIDTH-1:0]   r_rem_q;
   logic [2*WIDTH-1:0] r_acc;
   logic [c_CNT_W-1:0] r_i;
   logic [WIDTH-1:0]   r_rad;
   logic               r_ovf;
   logic               r_valid;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH:0]   w_sum;

`ifdef SQ_INT_REM_CHECK_EN
   logic               r_rem_err_q;
   logic               r_rem_err;
   logic               w_rem_big;

   // Compared one bit wider so 2*root cannot wrap
   assign w_rem_big = ({1'b0, rem} > {root, 1'b0});
   assign rem_err   = r_rem_err;
`else
   assign rem_err   = 1'b0;
`endif

   sq_int_r4_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc      (r_acc),
      .mcand    (r_mcand),
      .d        (r_mplr[WIDTH-1:WIDTH-2]),
      .acc_next (w_acc_next)
   );

   assign w_sum = {1'b0, r_acc} + {{(WIDTH+1){1'b0}}, r_rem_q};

   assign busy  = (r_state != S_IDLE);
   assign valid = r_valid;
   assign rad   = r_rad;
   assign ovf   = r_ovf;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state: start overrides everything, so a start while busy restarts
   always_comb begin
      w_next = r_state;
      if (start) begin
         w_next = S_MUL;
      end else begin
         case (r_state)
            S_MUL:   if (r_i == c_LAST) w_next = S_ADD;
            S_ADD:   w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Datapath: operand capture, shift-add iterations and final remainder add
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand     <= '0;
         r_mplr      <= '0;
         r_rem_q     <= '0;
         r_acc       <= '0;
         r_i         <= '0;
         r_rad       <= '0;
         r_ovf       <= 1'b0;
         r_valid     <= 1'b0;
`ifdef SQ_INT_REM_CHECK_EN
         r_rem_err_q <= 1'b0;
         r_rem_err   <= 1'b0;
`endif
      end else if (start) begin
         r_mcand     <= root;
         r_mplr      <= root;
         r_rem_q     <= rem;
         r_acc       <= '0;
         r_i         <= '0;
         r_valid     <= 1'b0;
`ifdef SQ_INT_REM_CHECK_EN
         r_rem_err_q <= w_rem_big;
         r_rem_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_MUL: begin
               r_acc  <= w_acc_next;
               r_mplr <= {r_mplr[WIDTH-3:0], 2'b00};
               if (r_i != c_LAST) begin
                  r_i <= r_i + c_CNT_W'(1);
               end
            end
            S_ADD: begin
               r_rad     <= w_sum[WIDTH-1:0];
               r_ovf     <= |w_sum[2*WIDTH:WIDTH];
               r_valid   <= 1'b1;
`ifdef SQ_INT_REM_CHECK_EN
               r_rem_err <= r_rem_err_q;
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sq_int.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_sq_int                                             |
// | Purpose  : Self-checking bench for sq_int at WIDTH=8 and 16.     |
// |            Honours SQ_INT_REM_CHECK_EN for the rem_err flag.     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_sq_int;

`ifdef SQ_INT_REM_CHECK_EN
   localparam bit c_CHECK = 1'b1;
`else
   localparam bit c_CHECK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0;
   logic [7:0]  root8  = '0;
   logic [7:0]  rem8   = '0;
   logic        busy8, valid8, ovf8, err8;
   logic [7:0]  rad8;

   logic        start16 = 1'b0;
   logic [15:0] root16  = '0;
   logic [15:0] rem16   = '0;
   logic        busy16, valid16, ovf16, err16;
   logic [15:0] rad16;

   int n_pass = 0;
   int n_tot  = 0;

   sq_int #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .busy(busy8), .valid(valid8),
      .root(root8), .rem(rem8), .rad(rad8), .ovf(ovf8), .rem_err(err8)
   );

   sq_int #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .busy(busy16), .valid(valid16),
      .root(root16), .rem(rem16), .rad(rad16), .ovf(ovf16), .rem_err(err16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic bit     in_start(int k); return (k == 0) ? start8 : start16; endfunction
   function automatic longint in_root(int k);  return (k == 0) ? longint'(root8) : longint'(root16); endfunction
   function automatic longint in_rem(int k);   return (k == 0) ? longint'(rem8)  : longint'(rem16);  endfunction
   function automatic bit     o_busy(int k);   return (k == 0) ? busy8  : busy16;  endfunction
   function automatic bit     o_valid(int k);  return (k == 0) ? valid8 : valid16; endfunction
   function automatic bit     o_ovf(int k);    return (k == 0) ? ovf8   : ovf16;   endfunction
   function automatic bit     o_err(int k);    return (k == 0) ? err8   : err16;   endfunction
   function automatic longint o_rad(int k);    return (k == 0) ? longint'(rad8) : longint'(rad16); endfunction

   // Transaction-level model: a result computed arithmetically at start,
   // released after a fixed latency of width/2+1 edges.
   int     m_cnt   [2];
   bit     m_busy  [2];
   bit     m_valid [2];
   bit     m_ovf   [2];
   bit     m_err   [2];
   longint m_rad   [2];
   bit     p_ovf   [2];
   bit     p_err   [2];
   longint p_rad   [2];

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         int     w;
         longint full;
         w = (k == 0) ? 8 : 16;
         if (rst) begin
            m_cnt[k] = 0; m_busy[k] = 0; m_valid[k] = 0;
            m_ovf[k] = 0; m_err[k] = 0;  m_rad[k] = 0;
         end else if (in_start(k)) begin
            full      = in_root(k) * in_root(k) + in_rem(k);
            p_rad[k]  = full % (64'sd1 << w);
            p_ovf[k]  = (full >= (64'sd1 << w));
            p_err[k]  = c_CHECK && (in_rem(k) > 2 * in_root(k));
            m_cnt[k]  = w / 2 + 1;
            m_busy[k] = 1; m_valid[k] = 0; m_err[k] = 0;
         end else if (m_cnt[k] > 0) begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
               m_busy[k] = 0; m_valid[k] = 1;
               m_rad[k] = p_rad[k]; m_ovf[k] = p_ovf[k]; m_err[k] = p_err[k];
            end
         end
      end
   end

   // Compare every output of both instances against the model each cycle
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("busy_w%0d", k ? 16 : 8),    o_busy(k),  m_busy[k]);
         chk($sformatf("valid_w%0d", k ? 16 : 8),   o_valid(k), m_valid[k]);
         chk($sformatf("rad_w%0d", k ? 16 : 8),     o_rad(k),   m_rad[k]);
         chk($sformatf("ovf_w%0d", k ? 16 : 8),     o_ovf(k),   m_ovf[k]);
         chk($sformatf("rem_err_w%0d", k ? 16 : 8), o_err(k),   m_err[k]);
      end
   end

   // Called at a falling edge: present operands with start for one cycle
   task automatic launch(input int k, input int r, input int e);
      if (k == 0) begin root8 = 8'(r); rem8 = 8'(e); start8 = 1'b1; end
      else begin root16 = 16'(r); rem16 = 16'(e); start16 = 1'b1; end
      @(negedge clk);
      if (k == 0) start8 = 1'b0; else start16 = 1'b0;
   endtask

   task automatic wait_valid(input int k, input int max);
      int n = 0;
      while (!o_valid(k) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", o_valid(k), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_busy", busy8, 0);
      chk("reset_valid", valid8, 0);
      chk("reset_rad", rad8, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: 11*11, busy for five cycles then valid
      launch(0, 11, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t1_busy", busy8, 1);
         @(negedge clk);
      end
      chk("t1_valid", valid8, 1);
      chk("t1_rad", rad8, 121);
      chk("t1_ovf", ovf8, 0);
      chk("t1_rem_err", err8, 0);

      // 2: largest fitting result, then the first overflowing one
      launch(0, 15, 30);
      wait_valid(0, 20);
      chk("t2a_rad", rad8, 255);
      chk("t2a_ovf", ovf8, 0);
      launch(0, 16, 0);
      wait_valid(0, 20);
      chk("t2b_rad", rad8, 0);
      chk("t2b_ovf", ovf8, 1);

      // 3: non-canonical remainder
      launch(0, 3, 7);
      wait_valid(0, 20);
      chk("t3_rad", rad8, 16);
      chk("t3_rem_err", err8, c_CHECK ? 1 : 0);

      // 4: restart two cycles after the first start
      launch(0, 5, 0);
      @(negedge clk);
      launch(0, 9, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t4_no_valid", valid8, 0);
         @(negedge clk);
      end
      chk("t4_valid", valid8, 1);
      chk("t4_rad", rad8, 81);

      // 5: asynchronous reset in the middle of the multiply phase
      launch(0, 7, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5_busy", busy8, 0);
      chk("t5_valid", valid8, 0);
      chk("t5_rad", rad8, 0);
      chk("t5_ovf", ovf8, 0);
      chk("t5_rem_err", err8, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      launch(0, 7, 1);
      wait_valid(0, 20);
      chk("t5_rad_after", rad8, 50);

      // 6: canonical sweep with back-to-back starts, both widths
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 16; r++) begin
            for (int e = 0; e <= 2 * r; e++) begin
               launch(k, r, e);
               wait_valid(k, 30);
               chk("sweep_rad", o_rad(k), r * r + e);
               chk("sweep_ovf", o_ovf(k), 0);
               chk("sweep_rem_err", o_err(k), 0);
            end
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
